// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM frame arbiter.
// FSM state encoding, command direction codes and default banks.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic CMD_WR = 1'b1;
  localparam logic CMD_RD = 1'b0;

  localparam logic [1:0] DEF_WR_BANK = 2'b00;
  localparam logic [1:0] DEF_RD_BANK = 2'b11;

endpackage

// File: rtl/frame_addr_gen.sv
// Per-side frame address counter with bank latch and done flag.
// Loads arriving mid-burst are parked until the burst retires.
module frame_addr_gen
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int LEN_W       = 9,
  parameter int BURST_LEN   = 256,
  parameter int FRAME_WORDS = 307200,
  parameter logic [1:0] DEF_BANK = DEF_WR_BANK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [1:0]        bank_in,
  input  logic              hold,
  input  logic              advance,
  output logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        bank,
  output logic              done
);

  localparam logic [ADDR_W-1:0] FW = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] BL = ADDR_W'(BURST_LEN);

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        bank_q;
  logic              done_q;
  logic              pend_q;
  logic [1:0]        pend_bank_q;
  logic [ADDR_W-1:0] rem;
  logic [ADDR_W-1:0] addr_nxt;

  // Remaining words bound the burst so the last one ends on the frame edge.
  always_comb begin
    rem      = FW - addr_q;
    len      = (rem >= BL) ? LEN_W'(BURST_LEN) : rem[LEN_W-1:0];
    addr_nxt = addr_q + ADDR_W'(len);
  end

  // Counter, bank latch, parked load and done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      bank_q      <= DEF_BANK;
      done_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_bank_q <= DEF_BANK;
    end else if (load && (!hold || advance)) begin
      addr_q <= '0;
      bank_q <= bank_in;
      done_q <= 1'b0;
      pend_q <= 1'b0;
    end else if (load) begin
      pend_q      <= 1'b1;
      pend_bank_q <= bank_in;
    end else if (advance) begin
      addr_q <= addr_nxt;
      done_q <= (addr_nxt == FW);
    end else if (pend_q && !hold) begin
      addr_q <= '0;
      bank_q <= pend_bank_q;
      done_q <= 1'b0;
      pend_q <= 1'b0;
    end
  end

  assign addr = addr_q;
  assign bank = bank_q;
  assign done = done_q;

endmodule

// File: rtl/sdram_frame_arbiter.sv
// Arbitrates one SDRAM controller between camera writes and display reads.
// Optional macro ARB_ROUND_ROBIN_EN: alternate sides on ties (else read wins).
module sdram_frame_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int LVL_W       = 10,
  parameter int LEN_W       = 9,
  parameter int BURST_LEN   = 256,
  parameter int FRAME_WORDS = 307200,
  parameter int WR_THRESH   = 256,
  parameter int RD_THRESH   = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_load,
  input  logic              rd_load,
  input  logic [1:0]        wr_bank,
  input  logic [1:0]        rd_bank,
  input  logic [LVL_W-1:0]  wr_fifo_used,
  input  logic [LVL_W-1:0]  rd_fifo_used,
  input  logic              rd_enable,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [1:0]        cmd_bank,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  input  logic              burst_done,
  output logic              frame_write_done,
  output logic              frame_read_done,
  output logic              busy
);

  state_t state_q, state_d;
  logic   sel_q, sel_d;
  logic   wr_req, rd_req, win_wr;
  logic   wr_hold, rd_hold, wr_adv, rd_adv;

  logic [LEN_W-1:0]  wr_len, rd_len;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [1:0]        wr_bank_l, rd_bank_l;
  logic              wr_done, rd_done;

  assign wr_req = (wr_fifo_used >= LVL_W'(WR_THRESH)) & ~wr_done;
  assign rd_req = rd_enable & (rd_fifo_used < LVL_W'(RD_THRESH)) & ~rd_done;

  assign wr_hold = (state_q != IDLE) & (sel_q == CMD_WR);
  assign rd_hold = (state_q != IDLE) & (sel_q == CMD_RD);
  assign wr_adv  = (state_q == WAIT) & (sel_q == CMD_WR) & burst_done;
  assign rd_adv  = (state_q == WAIT) & (sel_q == CMD_RD) & burst_done;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_wr_q;

  assign win_wr = wr_req & (~rd_req | ~last_wr_q);

  // Remember which side was granted last; starts as write so read wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_wr_q <= 1'b1;
    else if (state_q == IDLE && (wr_req || rd_req))
      last_wr_q <= win_wr;
  end
`else
  assign win_wr = wr_req & ~rd_req;
`endif

  frame_addr_gen #(
    .ADDR_W      (ADDR_W),
    .LEN_W       (LEN_W),
    .BURST_LEN   (BURST_LEN),
    .FRAME_WORDS (FRAME_WORDS),
    .DEF_BANK    (DEF_WR_BANK)
  ) u_wr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (wr_load),
    .bank_in (wr_bank),
    .hold    (wr_hold),
    .advance (wr_adv),
    .len     (wr_len),
    .addr    (wr_addr),
    .bank    (wr_bank_l),
    .done    (wr_done)
  );

  frame_addr_gen #(
    .ADDR_W      (ADDR_W),
    .LEN_W       (LEN_W),
    .BURST_LEN   (BURST_LEN),
    .FRAME_WORDS (FRAME_WORDS),
    .DEF_BANK    (DEF_RD_BANK)
  ) u_rd_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (rd_load),
    .bank_in (rd_bank),
    .hold    (rd_hold),
    .advance (rd_adv),
    .len     (rd_len),
    .addr    (rd_addr),
    .bank    (rd_bank_l),
    .done    (rd_done)
  );

  // State and granted-side registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= CMD_RD;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Next state and command outputs; command fields only live in ISSUE.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_bank  = '0;
    cmd_addr  = '0;
    cmd_len   = '0;
    unique case (state_q)
      IDLE: begin
        if (wr_req || rd_req) begin
          state_d = ISSUE;
          sel_d   = win_wr ? CMD_WR : CMD_RD;
        end
      end
      ISSUE: begin
        cmd_valid = 1'b1;
        cmd_write = sel_q;
        cmd_bank  = (sel_q == CMD_WR) ? wr_bank_l : rd_bank_l;
        cmd_addr  = (sel_q == CMD_WR) ? wr_addr : rd_addr;
        cmd_len   = (sel_q == CMD_WR) ? wr_len : rd_len;
        if (cmd_ready)
          state_d = WAIT;
      end
      WAIT: begin
        if (burst_done)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy             = (state_q != IDLE);
  assign frame_write_done = wr_done;
  assign frame_read_done  = rd_done;

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Directed bench for sdram_frame_arbiter (FRAME_WORDS=1000).
// Expected commands are hand-computed for both arbitration builds.
module tb_sdram_frame_arbiter;

  localparam int ADDR_W = 20;
  localparam int LVL_W  = 10;
  localparam int LEN_W  = 9;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_load, rd_load;
  logic [1:0]        wr_bank, rd_bank;
  logic [LVL_W-1:0]  wr_fifo_used, rd_fifo_used;
  logic              rd_enable;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [1:0]        cmd_bank;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              burst_done;
  logic              frame_write_done, frame_read_done, busy;

  int checks = 0;
  int fails  = 0;

  sdram_frame_arbiter #(
    .ADDR_W      (ADDR_W),
    .LVL_W       (LVL_W),
    .LEN_W       (LEN_W),
    .BURST_LEN   (256),
    .FRAME_WORDS (1000),
    .WR_THRESH   (256),
    .RD_THRESH   (512)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wr_load          (wr_load),
    .rd_load          (rd_load),
    .wr_bank          (wr_bank),
    .rd_bank          (rd_bank),
    .wr_fifo_used     (wr_fifo_used),
    .rd_fifo_used     (rd_fifo_used),
    .rd_enable        (rd_enable),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_write        (cmd_write),
    .cmd_bank         (cmd_bank),
    .cmd_addr         (cmd_addr),
    .cmd_len          (cmd_len),
    .burst_done       (burst_done),
    .frame_write_done (frame_write_done),
    .frame_read_done  (frame_read_done),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_fields(input string tag, input logic w,
                            input logic [1:0] b, input int a, input int l);
    chk({tag, "_valid"}, 32'(cmd_valid), 32'd1);
    chk({tag, "_write"}, 32'(cmd_write), 32'(w));
    chk({tag, "_bank"},  32'(cmd_bank),  32'(b));
    chk({tag, "_addr"},  32'(cmd_addr),  32'(a));
    chk({tag, "_len"},   32'(cmd_len),   32'(l));
  endtask

  task automatic expect_cmd(input string tag, input logic w,
                            input logic [1:0] b, input int a, input int l);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (cmd_valid === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) chk_fields(tag, w, b, a, l);
  endtask

  task automatic complete();
    repeat (10) @(negedge clk);
    burst_done = 1'b1;
    @(negedge clk);
    burst_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit any_valid;
    rst_n        = 1'b0;
    wr_load      = 1'b0;
    rd_load      = 1'b0;
    wr_bank      = 2'd0;
    rd_bank      = 2'd3;
    wr_fifo_used = '0;
    rd_fifo_used = '0;
    rd_enable    = 1'b0;
    cmd_ready    = 1'b1;
    burst_done   = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_wdone", 32'(frame_write_done), 32'd0);
    chk("rst_rdone", 32'(frame_read_done), 32'd0);

    // Write frame of 1000 words: three full bursts and a short one.
    rst_n        = 1'b1;
    wr_fifo_used = 10'd300;
    wr_load      = 1'b1;
    wr_bank      = 2'd0;
    @(negedge clk);
    wr_load = 1'b0;
    expect_cmd("w0", 1'b1, 2'd0, 0, 256);
    complete();
    chk("w0_wdone", 32'(frame_write_done), 32'd0);
    expect_cmd("w1", 1'b1, 2'd0, 256, 256);
    complete();
    expect_cmd("w2", 1'b1, 2'd0, 512, 256);
    complete();
    expect_cmd("w3", 1'b1, 2'd0, 768, 232);
    complete();
    chk("w3_wdone", 32'(frame_write_done), 32'd1);

    any_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (cmd_valid === 1'b1) any_valid = 1'b1;
    end
    chk("done_no_cmd", 32'(any_valid), 32'd0);
    chk("done_idle",   32'(busy), 32'd0);

    // New frame on bank 1, then a reload to bank 2 mid-burst.
    wr_load = 1'b1;
    wr_bank = 2'd1;
    @(negedge clk);
    wr_load = 1'b0;
    chk("ld_wdone_clr", 32'(frame_write_done), 32'd0);
    expect_cmd("wb1", 1'b1, 2'd1, 0, 256);
    repeat (3) @(negedge clk);
    chk("wait_busy", 32'(busy), 32'd1);
    wr_load = 1'b1;
    wr_bank = 2'd2;
    @(negedge clk);
    wr_load = 1'b0;
    repeat (6) @(negedge clk);
    burst_done = 1'b1;
    @(negedge clk);
    burst_done = 1'b0;
    expect_cmd("wb2", 1'b1, 2'd2, 0, 256);

    // Enable reads during this burst so both sides contend afterwards.
    @(negedge clk);
    rd_enable = 1'b1;
    rd_load   = 1'b1;
    rd_bank   = 2'd3;
    @(negedge clk);
    rd_load = 1'b0;
    complete();

`ifdef ARB_ROUND_ROBIN_EN
    expect_cmd("t0", 1'b0, 2'd3, 0, 256);
    complete();
    expect_cmd("t1", 1'b1, 2'd2, 256, 256);
    complete();
    expect_cmd("t2", 1'b0, 2'd3, 256, 256);
    complete();
    expect_cmd("t3", 1'b1, 2'd2, 512, 256);
    complete();
`else
    expect_cmd("t0", 1'b0, 2'd3, 0, 256);
    complete();
    expect_cmd("t1", 1'b0, 2'd3, 256, 256);
    complete();
    expect_cmd("t2", 1'b0, 2'd3, 512, 256);
    complete();
    expect_cmd("t3", 1'b0, 2'd3, 768, 232);
    complete();
    chk("t3_rdone", 32'(frame_read_done), 32'd1);
`endif

    // Controller stalls: command must hold steady until accepted.
    cmd_ready = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    expect_cmd("st0", 1'b0, 2'd3, 512, 256);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      chk_fields("st_hold", 1'b0, 2'd3, 512, 256);
    end
`else
    expect_cmd("st0", 1'b1, 2'd2, 256, 256);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      chk_fields("st_hold", 1'b1, 2'd2, 256, 256);
    end
`endif
    cmd_ready = 1'b1;
    @(negedge clk);
    chk("st_acc_valid", 32'(cmd_valid), 32'd0);
    chk("st_acc_busy",  32'(busy), 32'd1);

    // Asynchronous reset in the middle of a burst.
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(cmd_valid), 32'd0);
    chk("ar_busy",  32'(busy), 32'd0);
    chk("ar_wdone", 32'(frame_write_done), 32'd0);
    chk("ar_rdone", 32'(frame_read_done), 32'd0);
    chk("ar_addr",  32'(cmd_addr), 32'd0);
    @(negedge clk);
    rd_enable = 1'b0;
    rst_n     = 1'b1;
    expect_cmd("ar_w0", 1'b1, 2'd0, 0, 256);
    complete();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
